// File: rtl/rv32im_pkg.sv
// rv32im_pkg: shared definitions for the RV32IM decode stage and the ALU.
//   - opcode / funct3 / funct7 constants
//   - op_idx_e: bit index of each operation inside the 31-bit one-hot
//     enable vector (bit 30 = mul ... bit 0 = auipc)
//   - decode_payload_t: the record carried from decode to execute
//   - op_onehot(): builds the enable vector for one operation
package rv32im_pkg;

  localparam int NUM_OPS = 31;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  // ALU-class funct3 values (OP and OP-IMM)
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // M-extension funct3 values
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Store funct3 values
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [4:0] {
    OP_AUIPC,  OP_LUI,   OP_SB,    OP_SH,    OP_SW,
    OP_SRAI,   OP_SRLI,  OP_SLLI,  OP_SLTIU, OP_SLTI,
    OP_XORI,   OP_ORI,   OP_ANDI,  OP_ADDI,  OP_SLT,
    OP_SRA,    OP_SRL,   OP_SLL,   OP_XOR,   OP_OR,
    OP_AND,    OP_SUB,   OP_ADD,   OP_REMU,  OP_REM,
    OP_DIVU,   OP_DIV,   OP_MULHU, OP_MULHSU, OP_MULH,
    OP_MUL
  } op_idx_e;

  typedef struct packed {
    logic [NUM_OPS-1:0] en;
    logic [31:0]        im_i;
    logic [31:0]        im_s;
    logic [31:0]        im_u;
    logic [4:0]         shamt;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [31:0]        pc;
    logic               illegal;
  } decode_payload_t;

  function automatic logic [NUM_OPS-1:0] op_onehot(input op_idx_e op);
    return NUM_OPS'(1) << op;
  endfunction

endpackage

// File: rtl/rv32im_decode_stage_if.sv
// rv32im_decode_stage_if: input (fetch) and output (execute) handshakes of
// the decode stage.
//   master modport: the environment (drives in_*, out_ready)
//   slave  modport: the decode stage (drives in_ready, out_*)
//
// Handshake rule, identical on both sides: a transfer happens on a rising
// clock edge where valid and ready are both 1. A producer holding valid=1
// keeps its payload stable until the transfer; ready may be asserted
// regardless of valid, and in_ready never depends combinationally on
// out_ready.
interface rv32im_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_en;
  logic [31:0] out_im_i;
  logic [31:0] out_im_s;
  logic [31:0] out_im_u;
  logic [4:0]  out_shamt;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_en, out_im_i, out_im_s, out_im_u,
           out_shamt, out_rs1, out_rs2, out_rd, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_en, out_im_i, out_im_s, out_im_u,
           out_shamt, out_rs1, out_rs2, out_rd, out_pc, out_illegal
  );
endinterface

// File: rtl/rv32im_decode_comb.sv
// rv32im_decode_comb: pure combinational RV32IM decoder.
//   instr   in  32  instruction word
//   pc      in  32  instruction address (passed through)
//   payload out     one-hot op enable, immediates, shamt, register
//                   indices, pc and illegal flag
// Fields are extracted for every format; only en/illegal depend on the
// opcode. An unsupported instruction yields en=0, illegal=1.
module rv32im_decode_comb
  import rv32im_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [31:0]     pc,
  output decode_payload_t payload
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [NUM_OPS-1:0] en;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    en = '0;
    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_MULDIV: begin
            case (funct3)
              F3_MUL:    en = op_onehot(OP_MUL);
              F3_MULH:   en = op_onehot(OP_MULH);
              F3_MULHSU: en = op_onehot(OP_MULHSU);
              F3_MULHU:  en = op_onehot(OP_MULHU);
              F3_DIV:    en = op_onehot(OP_DIV);
              F3_DIVU:   en = op_onehot(OP_DIVU);
              F3_REM:    en = op_onehot(OP_REM);
              F3_REMU:   en = op_onehot(OP_REMU);
              default:   en = '0;
            endcase
          end
          F7_BASE: begin
            // sltu (F3_SLTU) is deliberately not supported
            case (funct3)
              F3_ADD_SUB: en = op_onehot(OP_ADD);
              F3_SLL:     en = op_onehot(OP_SLL);
              F3_SLT:     en = op_onehot(OP_SLT);
              F3_XOR:     en = op_onehot(OP_XOR);
              F3_SRL_SRA: en = op_onehot(OP_SRL);
              F3_OR:      en = op_onehot(OP_OR);
              F3_AND:     en = op_onehot(OP_AND);
              default:    en = '0;
            endcase
          end
          F7_ALT: begin
            case (funct3)
              F3_ADD_SUB: en = op_onehot(OP_SUB);
              F3_SRL_SRA: en = op_onehot(OP_SRA);
              default:    en = '0;
            endcase
          end
          default: en = '0;
        endcase
      end
      OPC_OP_IMM: begin
        case (funct3)
          F3_ADD_SUB: en = op_onehot(OP_ADDI);
          F3_SLT:     en = op_onehot(OP_SLTI);
          F3_SLTU:    en = op_onehot(OP_SLTIU);
          F3_XOR:     en = op_onehot(OP_XORI);
          F3_OR:      en = op_onehot(OP_ORI);
          F3_AND:     en = op_onehot(OP_ANDI);
          // Shift-immediates reuse imm[11:5] as funct7; other encodings are illegal
          F3_SLL:     en = (funct7 == F7_BASE) ? op_onehot(OP_SLLI) : '0;
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE)     en = op_onehot(OP_SRLI);
            else if (funct7 == F7_ALT) en = op_onehot(OP_SRAI);
            else                       en = '0;
          end
          default:    en = '0;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          F3_SB:   en = op_onehot(OP_SB);
          F3_SH:   en = op_onehot(OP_SH);
          F3_SW:   en = op_onehot(OP_SW);
          default: en = '0;
        endcase
      end
      OPC_LUI:   en = op_onehot(OP_LUI);
      OPC_AUIPC: en = op_onehot(OP_AUIPC);
      default:   en = '0;
    endcase
  end

  always_comb begin
    payload         = '0;
    payload.en      = en;
    payload.im_i    = {{20{instr[31]}}, instr[31:20]};
    payload.im_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    payload.im_u    = {12'b0, instr[31:12]};
    payload.shamt   = instr[24:20];
    payload.rs1     = instr[19:15];
    payload.rs2     = instr[24:20];
    payload.rd      = instr[11:7];
    payload.pc      = pc;
    // Every legal encoding sets exactly one enable bit
    payload.illegal = (en == '0);
  end

endmodule

// File: rtl/rv32im_decode_stage.sv
// rv32im_decode_stage: registered decode stage with a 2-entry skid buffer.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; drops both entries
//   flush  in   synchronous; drops both entries and any input this cycle
//   bus    slave modport of rv32im_decode_stage_if
//            in_valid/in_ready/in_instr/in_pc     fetch side
//            out_valid/out_ready/out_*             execute side
// The main register drives the outputs. The skid register catches the one
// entry accepted while main is stalled, so in_ready can be a flop
// (!skid_valid) with no combinational path from out_ready.
module rv32im_decode_stage
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  rv32im_decode_stage_if.slave bus
);

  logic [XLEN-1:0] in_pc;
  decode_payload_t dec_payload;

  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  decode_payload_t main_q, main_d;
  decode_payload_t skid_q, skid_d;

  logic            accept;
  logic            out_xfer;

  assign in_pc = bus.in_pc;

  rv32im_decode_comb u_decode (
    .instr   (bus.in_instr),
    .pc      (in_pc),
    .payload (dec_payload)
  );

  assign accept   = bus.in_valid && !skid_valid_q;
  assign out_xfer = main_valid_q && bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_xfer || !main_valid_q) begin
      // Main slot is free next cycle: the skid entry is older, so it goes
      // first; while skid is full accept is 0, leaving skid empty after.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec_payload;
      end
    end else if (accept) begin
      // Main is stalled: park the new entry in the skid slot
      skid_valid_d = 1'b1;
      skid_d       = dec_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_en      = main_q.en;
  assign bus.out_im_i    = main_q.im_i;
  assign bus.out_im_s    = main_q.im_s;
  assign bus.out_im_u    = main_q.im_u;
  assign bus.out_shamt   = main_q.shamt;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: doc/rv32im_decode_stage.md
Name: rv32im_decode_stage

Overview:
Decode pipeline stage that produces the execute-stage ALU's operand controls: the 31-bit one-hot operation enable vector, the I/S/U immediates, shift amount and register indices. It accepts fetched instruction/PC pairs over a valid/ready handshake and presents registered results downstream through a 2-entry skid buffer. It runs at full throughput with 1-cycle latency and supports a synchronous flush.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; asynchronous assert, active-low
flush  in  1  synchronous; discards all buffered entries
in_valid  in  1  instr/pc valid
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  32  instruction address
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts
out_en  out  31  one-hot op enable; bit30..0 = mul,mulh,mulhsu,mulhu,div,divu,rem,remu,add,sub,and,or,xor,sll,srl,sra,slt,addi,andi,ori,xori,slti,sltiu,slli,srli,srai,sw,sh,sb,lui,auipc
out_im_i  out  32  sign-extended instr[31:20]
out_im_s  out  32  sign-extended {instr[31:25],instr[11:7]}
out_im_u  out  32  {12'b0, instr[31:12]}, unshifted; the ALU applies <<12
out_shamt  out  5  instr[24:20]
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_pc  out  32  pass-through PC
out_illegal  out  1  instruction not among the 31 supported ops

Behaviour:
- Reset (rst_n low, async): both buffer entries invalid. out_valid=0, in_ready=1, all data outputs 0.
- Decode is combinational on in_instr; results are captured on an accepted transfer (in_valid & in_ready). Latency is 1 cycle from acceptance to out_valid.
- Main register holds the presented entry. Skid register captures an accepted entry when the main register is valid and out_ready=0.
- in_ready = !skid_valid (registered, no combinational path from out_ready).
- Output transfer occurs on out_valid & out_ready. On that transfer the skid entry moves into main, otherwise main reloads from input or goes invalid.
- Simultaneous accept and output transfer with skid empty: main loads the new entry, giving 1 per cycle sustained throughput.
- Full (main and skid valid): in_ready=0 and input is ignored. An output transfer frees the skid, so in_ready=1 on the next cycle.
- flush has priority over all transfers. Next cycle: both entries invalid, in_ready=1, and an input presented in the flush cycle is dropped.
- Reset mid-operation drops all entries immediately.
- Decode table (out_en has exactly one bit set, or none when illegal):
  - opcode 0110011, funct7 0000001: funct3 000..111 = mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
  - opcode 0110011, funct7 0000000: 000 add, 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and.
  - opcode 0110011, funct7 0100000: 000 sub, 101 sra. All other R-type combinations, including funct3 011 (sltu), are illegal.
  - opcode 0010011: 000 addi, 010 slti, 011 sltiu, 100 xori, 110 ori, 111 andi. 001 is slli only when funct7=0000000. 101 is srli (funct7 0000000) or srai (funct7 0100000). Anything else is illegal.
  - opcode 0100011: 000 sb, 001 sh, 010 sw; other funct3 is illegal.
  - opcode 0110111 is lui; opcode 0010111 is auipc.
  - Any other opcode (loads, branches, jal, system, all-zero word): out_en=0, out_illegal=1. The entry still flows downstream.
- Immediates, indices and shamt are always extracted regardless of format.
- out_pc equals in_pc unmodified.

Decomposition:
- Shared package rv32im_pkg holds:
  - opcode constants;
  - funct3/funct7 constants;
  - a 31-bit op-enable bit-index enumeration in the order above, also used by the ALU.
- Payload struct type: en, three immediates, shamt, rs1, rs2, rd, pc, illegal.
- One natural sub-module is rv32im_decode_comb, the pure combinational decoder (instr -> payload). The stage instantiates it ahead of the skid buffer.

Test Plan:
- Reset: hold rst_n=0, then release -> out_valid=0, in_ready=1, out_en=0.
- add 0x002081B3 at pc 0x100 -> next cycle out_valid=1, out_en=0x00400000, rs1=1, rs2=2, rd=3, out_pc=0x100. Then mul 0x022081B3 -> out_en=0x40000000.
- Immediate ops:
  - addi 0xFFF00093 -> out_en=0x00002000, out_im_i=0xFFFFFFFF.
  - sw 0x0020A423 -> out_en=0x00000010, out_im_s=0x00000008.
  - lui 0x123452B7 -> out_en=0x00000002, out_im_u=0x00012345, rd=5.
- Illegal: 0x00000000 and sltu 0x0020B1B3 -> out_illegal=1, out_en=0.
- Backpressure: stream 4 instructions with out_ready=0 -> 2 accepted, then in_ready=0. Raise out_ready -> all 4 emerge in order, none lost or duplicated, 1 per cycle.
- Flush: fill both entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed instructions never appear.
